// File: rtl/remote_cmd_xmtr.sv
// Host-side UART command link: sends a 16-bit command as two 8N1 frames (high byte first)
// and receives single-byte responses. TX and RX paths run independently.
//   state  | meaning
//   C_IDLE | waiting for send_cmd
//   C_HIGH | high byte on the wire
//   C_LOW  | low byte on the wire
//   R_IDLE | waiting for a start edge on RX
//   R_RECV | sampling start, 8 data and stop bits
module remote_cmd_xmtr #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        send_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {C_IDLE, C_HIGH, C_LOW} cmd_state_t;
  typedef enum logic {R_IDLE, R_RECV} rx_state_t;

  cmd_state_t  cst_q, cst_d;
  logic [15:0] shadow_q, shadow_d;
  logic        cmd_sent_q, cmd_sent_d;
  logic        cmd_accept, tx_load, tx_done;
  logic [7:0]  tx_byte;

  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [11:0] tx_baud_q, tx_baud_d;
  logic [3:0]  tx_bit_q, tx_bit_d;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t   rst_q, rst_d;
  logic [11:0] rx_baud_q, rx_baud_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_rdy_q, resp_rdy_d;
  logic        rx_fall, rx_clear, rx_done;

  always_comb begin
    cst_d      = cst_q;
    shadow_d   = shadow_q;
    cmd_sent_d = cmd_sent_q;
    cmd_accept = 1'b0;
    tx_load    = 1'b0;
    tx_byte    = 8'h00;
    case (cst_q)
      C_IDLE: if (send_cmd) begin
        cmd_accept = 1'b1;
        shadow_d   = cmd;
        cmd_sent_d = 1'b0;
        tx_load    = 1'b1;
        tx_byte    = cmd[15:8];
        cst_d      = C_HIGH;
      end
      C_HIGH: if (tx_done) begin
        tx_load = 1'b1;
        tx_byte = shadow_q[7:0];
        cst_d   = C_LOW;
      end
      C_LOW: if (tx_done) begin
        cmd_sent_d = 1'b1;
        cst_d      = C_IDLE;
      end
      default: cst_d = C_IDLE;
    endcase
  end

  // A load on the tx_done cycle restarts the frame directly, so bytes abut with no idle gap.
  assign tx_done = tx_busy_q && (tx_baud_q == 12'd0) && (tx_bit_q == 4'd0);

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    if (tx_load) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_baud_d  = BAUD_LAST;
      tx_bit_d   = 4'd9;
    end else if (tx_busy_q) begin
      if (tx_baud_q != 12'd0) begin
        tx_baud_d = tx_baud_q - 12'd1;
      end else if (tx_bit_q == 4'd0) begin
        tx_busy_d = 1'b0;
      end else begin
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q - 4'd1;
        tx_baud_d  = BAUD_LAST;
      end
    end
  end

  // Driven from reset-cleared flops so reset forces the line high without waiting for a clock.
  assign TX = ~tx_busy_q | tx_shift_q[0];

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    rst_d      = rst_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    rx_clear   = 1'b0;
    rx_done    = 1'b0;
    case (rst_q)
      R_IDLE: if (rx_fall) begin
        rst_d     = R_RECV;
        rx_baud_d = HALF_LAST;
        rx_bit_d  = 4'd0;
        rx_clear  = 1'b1;
      end
      R_RECV: begin
        if (rx_baud_q != 12'd0) begin
          rx_baud_d = rx_baud_q - 12'd1;
        end else begin
          rx_baud_d = BAUD_LAST;
          rx_bit_d  = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd0) begin
            if (rx_sync_q) rst_d = R_IDLE;
          end else if (rx_bit_q == 4'd9) begin
            resp_d  = rx_shift_q;
            rx_done = 1'b1;
            rst_d   = R_IDLE;
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    resp_rdy_d = resp_rdy_q;
    if (rx_done) resp_rdy_d = 1'b1;
    else if (rx_clear || cmd_accept) resp_rdy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cst_q      <= C_IDLE;
      shadow_q   <= 16'h0000;
      cmd_sent_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= 10'h3FF;
      tx_baud_q  <= 12'd0;
      tx_bit_q   <= 4'd0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rst_q      <= R_IDLE;
      rx_baud_q  <= 12'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      cst_q      <= cst_d;
      shadow_q   <= shadow_d;
      cmd_sent_q <= cmd_sent_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rst_q      <= rst_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_cmd_xmtr.sv
// Bench for remote_cmd_xmtr: bench-side UART receiver/transmitter plus a byte-queue model
// of what should appear on TX and in resp.
module tb_remote_cmd_xmtr;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        RST_n;
  logic        send_cmd;
  logic [15:0] cmd;
  logic        TX;
  logic        RX;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_resp;

  remote_cmd_xmtr #(.BAUD_DIV(B)) dut (
    .clk(clk), .RST_n(RST_n), .send_cmd(send_cmd), .cmd(cmd),
    .TX(TX), .RX(RX), .cmd_sent(cmd_sent), .resp(resp), .resp_rdy(resp_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic capture_byte(output logic [7:0] b);
    int n = 0;
    b = 8'h00;
    while (TX !== 1'b0 && n < 30 * B) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", TX, 0);
    repeat (B / 2) @(negedge clk);
    chk("tx_start_bit", TX, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(negedge clk);
      b[i] = TX;
    end
    repeat (B) @(negedge clk);
    chk("tx_stop_bit", TX, 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    RX = 1'b0;
    repeat (6) @(negedge clk);
    chk("rx_rdy_clr_at_start", resp_rdy, 0);
    repeat (B - 6) @(negedge clk);
    for (int i = 1; i < 10; i++) begin
      if (i == 9) chk("rx_rdy_not_early", resp_rdy, 0);
      RX = fr[i];
      repeat (B) @(negedge clk);
    end
    chk("rx_rdy_set", resp_rdy, 1);
    chk("rx_resp", resp, b);
    exp_resp = b;
  endtask

  task automatic run_cmd(input logic [15:0] c, input int extra_at);
    logic [7:0] hi, lo, e;
    int lat;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    cmd = 16'($urandom);
    lat = 1;
    chk("cmd_sent_clr", cmd_sent, 0);
    chk("resp_rdy_clr_on_send", resp_rdy, 0);
    fork
      begin
        capture_byte(hi);
        capture_byte(lo);
      end
      begin
        while (cmd_sent !== 1'b1 && lat < 25 * B) begin
          @(negedge clk);
          lat++;
        end
      end
      begin
        if (extra_at > 0) begin
          repeat (extra_at) @(negedge clk);
          cmd = 16'hFFFF;
          send_cmd = 1'b1;
          @(negedge clk);
          send_cmd = 1'b0;
        end
      end
    join
    e = exp_q.pop_front();
    chk("tx_high_byte", hi, e);
    e = exp_q.pop_front();
    chk("tx_low_byte", lo, e);
    chk("cmd_sent_set", cmd_sent, 1);
    chk_range("cmd_latency", lat, 20 * B - 4, 20 * B + 4);
  endtask

  initial begin
    logic seen_low;
    logic [15:0] rc;
    logic [7:0]  rr;
    int dly;
    RST_n = 1'b0;
    RX = 1'b1;
    send_cmd = 1'b0;
    cmd = 16'h0000;
    exp_resp = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1);
    chk("rst_cmd_sent", cmd_sent, 0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_resp_rdy", resp_rdy, 0);
    RST_n = 1'b1;
    repeat (3) @(negedge clk);

    run_cmd(16'h2000, 0);

    repeat (5) @(negedge clk);
    send_rx(8'hA5);
    repeat (B) @(negedge clk);
    send_rx(8'h5A);
    repeat (B) @(negedge clk);

    run_cmd(16'h4321, 5 * B);
    seen_low = 1'b0;
    repeat (25 * B) begin
      @(negedge clk);
      if (TX === 1'b0) seen_low = 1'b1;
    end
    chk("no_frame_from_ignored_send", seen_low, 0);
    chk("cmd_sent_held", cmd_sent, 1);

    fork
      run_cmd(16'h5BF1, 0);
      begin
        repeat (3 * B) @(negedge clk);
        send_rx(8'hA5);
      end
    join
    chk("overlap_cmd_sent", cmd_sent, 1);
    chk("overlap_resp_rdy", resp_rdy, 1);
    chk("overlap_resp", resp, 8'hA5);

    for (int k = 0; k < 3; k++) begin
      rc = 16'($urandom);
      rr = 8'($urandom);
      dly = $urandom_range(20, 100);
      fork
        run_cmd(rc, 0);
        begin
          repeat (dly) @(negedge clk);
          send_rx(rr);
        end
      join
      chk("rand_resp_rdy", resp_rdy, 1);
      chk("rand_resp", resp, rr);
      repeat (B) @(negedge clk);
    end

    cmd = 16'h2000;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    repeat (3 * B) @(negedge clk);
    chk("pre_reset_tx_low", TX, 0);
    RST_n = 1'b0;
    #1;
    chk("mid_reset_tx", TX, 1);
    chk("mid_reset_cmd_sent", cmd_sent, 0);
    chk("mid_reset_resp_rdy", resp_rdy, 0);
    exp_resp = 8'h00;
    repeat (2) @(negedge clk);
    RST_n = 1'b1;
    repeat (25 * B) @(negedge clk);
    chk("no_cmd_sent_after_abort", cmd_sent, 0);
    run_cmd(16'h2000, 0);

    repeat (B) @(negedge clk);
    RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("glitch_no_rdy", resp_rdy, 0);
    chk("glitch_resp_kept", resp, exp_resp);
    send_rx(8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
